// File: rtl/qspi_fetch_buffer_if.sv
// Bus bundle for the instruction prefetch buffer: CPU fetch side plus flash controller side.
// The buffer itself uses the slave view; whatever drives it (CPU/flash model) uses the master view.
interface qspi_fetch_buffer_if #(
  parameter int ADDR_BITS = 24
);
  logic [ADDR_BITS-1:0] fetch_addr_in;
  logic                 fetch_start;
  logic                 fetch_stop;

  logic [15:0]          instr_out;
  logic [ADDR_BITS-1:0] instr_addr;
  logic                 instr_valid;
  logic                 instr_ready;

  logic [ADDR_BITS-1:0] flash_addr_out;
  logic                 flash_start_read;
  logic                 flash_stall_read;
  logic                 flash_stop_read;
  logic [15:0]          flash_data_in;
  logic                 flash_data_ready;
  logic                 flash_busy;

  modport master (
    output fetch_addr_in, fetch_start, fetch_stop, instr_ready,
           flash_data_in, flash_data_ready, flash_busy,
    input  instr_out, instr_addr, instr_valid,
           flash_addr_out, flash_start_read, flash_stall_read, flash_stop_read
  );

  modport slave (
    input  fetch_addr_in, fetch_start, fetch_stop, instr_ready,
           flash_data_in, flash_data_ready, flash_busy,
    output instr_out, instr_addr, instr_valid,
           flash_addr_out, flash_start_read, flash_stall_read, flash_stop_read
  );
endinterface

// File: rtl/qspi_fetch_buffer.sv
// Instruction prefetch buffer: drives sequential flash reads, queues returned halfwords
// and hands them to the CPU as little-endian 16-bit parcels, with redirect/stop support.
module qspi_fetch_buffer #(
  parameter int DEPTH     = 4,
  parameter int ADDR_BITS = 24
) (
  input logic                clk,
  input logic                rstn,
  qspi_fetch_buffer_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    STOP,
    START,
    STREAM
  } state_e;

  state_e               state_q,      state_d;
  logic                 stopToIdle_q, stopToIdle_d;
  logic [ADDR_BITS-1:0] addr_q,       addr_d;
  logic                 startRead_q,  startRead_d;
  logic                 stopRead_q,   stopRead_d;
  logic                 stall_q,      stall_d;
  logic                 captured_q,   captured_d;
  logic [PTR_W-1:0]     wrPtr_q,      wrPtr_d;
  logic [PTR_W-1:0]     rdPtr_q,      rdPtr_d;
  logic [CNT_W-1:0]     count_q,      count_d;
  logic [ADDR_BITS-1:0] instrAddr_q,  instrAddr_d;
  logic [15:0]          mem_q [DEPTH];

  logic                 flush;
  logic                 pushEn;
  logic                 popEn;
  logic                 headValid;
  logic [ADDR_BITS-1:0] startAddr;

  assign startAddr = bus.fetch_addr_in & ~ADDR_BITS'(1);
  assign headValid = (count_q != '0);

  // Control FSM: fetch_start outranks fetch_stop, which outranks normal progress.
  always_comb begin
    state_d      = state_q;
    stopToIdle_d = stopToIdle_q;
    addr_d       = addr_q;
    startRead_d  = 1'b0;
    flush        = 1'b0;

    if (bus.fetch_start) begin
      addr_d       = startAddr;
      flush        = 1'b1;
      stopToIdle_d = 1'b0;
      if (state_q == IDLE) begin
        state_d     = START;
        startRead_d = !bus.flash_busy;
      end else begin
        state_d = STOP;
      end
    end else if (bus.fetch_stop && (state_q != IDLE)) begin
      flush        = 1'b1;
      stopToIdle_d = 1'b1;
      state_d      = STOP;
    end else begin
      case (state_q)
        STOP:    state_d = stopToIdle_q ? IDLE : START;
        START: begin
          // The start pulse is visible while still in START; leave once it has been issued.
          if (startRead_q) begin
            state_d = STREAM;
          end else begin
            startRead_d = !bus.flash_busy;
          end
        end
        default: ;
      endcase
    end
  end

  // The controller holds data_ready across stalls, so each word is taken on its first ready cycle only.
  always_comb begin
    pushEn     = (state_q == STREAM) && !captured_q && bus.flash_data_ready && !flush;
    popEn      = headValid && bus.instr_ready && !flush;
    captured_d = captured_q;
    if (!bus.flash_data_ready) begin
      captured_d = 1'b0;
    end else if (pushEn) begin
      captured_d = 1'b1;
    end
  end

  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    count_d     = count_q;
    instrAddr_d = instrAddr_q;

    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
      if (bus.fetch_start) begin
        instrAddr_d = startAddr;
      end
    end else begin
      if (pushEn) begin
        wrPtr_d = wrPtr_q + PTR_W'(1);
      end
      if (popEn) begin
        rdPtr_d     = rdPtr_q + PTR_W'(1);
        instrAddr_d = instrAddr_q + ADDR_BITS'(2);
      end
      case ({pushEn, popEn})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: ;
      endcase
    end

    stopRead_d = (state_d == STOP);
    stall_d    = (state_d == STREAM) && (count_d >= CNT_W'(DEPTH - 1));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      stopToIdle_q <= 1'b0;
      addr_q       <= '0;
      startRead_q  <= 1'b0;
      stopRead_q   <= 1'b0;
      stall_q      <= 1'b0;
      captured_q   <= 1'b0;
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      count_q      <= '0;
      instrAddr_q  <= '0;
    end else begin
      state_q      <= state_d;
      stopToIdle_q <= stopToIdle_d;
      addr_q       <= addr_d;
      startRead_q  <= startRead_d;
      stopRead_q   <= stopRead_d;
      stall_q      <= stall_d;
      captured_q   <= captured_d;
      wrPtr_q      <= wrPtr_d;
      rdPtr_q      <= rdPtr_d;
      count_q      <= count_d;
      instrAddr_q  <= instrAddr_d;
    end
  end

  // Flash returns big-endian halfwords; byte-swap on entry so the head is already little-endian.
  always_ff @(posedge clk) begin
    if (pushEn) begin
      mem_q[wrPtr_q] <= {bus.flash_data_in[7:0], bus.flash_data_in[15:8]};
    end
  end

  assign bus.instr_valid      = headValid;
  assign bus.instr_out        = headValid ? mem_q[rdPtr_q] : 16'h0000;
  assign bus.instr_addr       = instrAddr_q;
  assign bus.flash_addr_out   = addr_q;
  assign bus.flash_start_read = startRead_q;
  assign bus.flash_stop_read  = stopRead_q;
  assign bus.flash_stall_read = stall_q;

endmodule

// File: tb/tb_qspi_fetch_buffer.sv
// Directed self-checking bench for qspi_fetch_buffer; the bench plays both CPU and flash controller.
module tb_qspi_fetch_buffer;

  localparam int DEPTH     = 4;
  localparam int ADDR_BITS = 24;

  logic clk = 1'b0;
  logic rstn;
  int   checkCount = 0;
  int   errorCount = 0;

  qspi_fetch_buffer_if #(.ADDR_BITS(ADDR_BITS)) bus ();

  qspi_fetch_buffer #(.DEPTH(DEPTH), .ADDR_BITS(ADDR_BITS)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One flash word: data_ready held for 'hold' cycles, then one low cycle so the next word is distinct.
  task automatic applyStimulus(input logic [15:0] data, input int hold);
    bus.flash_data_in    = data;
    bus.flash_data_ready = 1'b1;
    repeat (hold) step();
    bus.flash_data_ready = 1'b0;
    step();
  endtask

  task automatic popOne();
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
  endtask

  task automatic expectHead(input string tag, input logic [15:0] data, input logic [23:0] addr);
    checkOutput({tag, "Valid"}, 32'(bus.instr_valid), 32'd1);
    checkOutput({tag, "Data"},  32'(bus.instr_out),   32'(data));
    checkOutput({tag, "Addr"},  32'(bus.instr_addr),  32'(addr));
  endtask

  task automatic expectAllZero(input string tag);
    checkOutput({tag, "Valid"},     32'(bus.instr_valid),      32'd0);
    checkOutput({tag, "Data"},      32'(bus.instr_out),        32'd0);
    checkOutput({tag, "Addr"},      32'(bus.instr_addr),       32'd0);
    checkOutput({tag, "FlashAddr"}, 32'(bus.flash_addr_out),   32'd0);
    checkOutput({tag, "Start"},     32'(bus.flash_start_read), 32'd0);
    checkOutput({tag, "Stop"},      32'(bus.flash_stop_read),  32'd0);
    checkOutput({tag, "Stall"},     32'(bus.flash_stall_read), 32'd0);
  endtask

  task automatic waitStartPulse(input string tag, input logic [23:0] addr);
    int n = 0;
    while (bus.flash_start_read !== 1'b1 && n < 16) begin
      step();
      n++;
    end
    checkOutput({tag, "StartSeen"}, 32'(bus.flash_start_read), 32'd1);
    checkOutput({tag, "StartAddr"}, 32'(bus.flash_addr_out),   32'(addr));
  endtask

  // A push must never land on a full queue.
  always @(negedge clk) begin
    if (rstn && dut.pushEn) begin
      checkOutput("pushWhenFull", 32'(int'(dut.count_q) >= DEPTH), 32'd0);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    rstn                 = 1'b0;
    bus.fetch_addr_in    = '0;
    bus.fetch_start      = 1'b0;
    bus.fetch_stop       = 1'b0;
    bus.instr_ready      = 1'b0;
    bus.flash_data_in    = '0;
    bus.flash_data_ready = 1'b0;
    bus.flash_busy       = 1'b0;
    repeat (2) step();
    expectAllZero("reset");
    rstn = 1'b1;
    step();

    $display("[TB] basic fetch from 0x000100");
    bus.fetch_addr_in = 24'h000100;
    bus.fetch_start   = 1'b1;
    step();
    bus.fetch_start = 1'b0;
    checkOutput("startPulse", 32'(bus.flash_start_read), 32'd1);
    checkOutput("startAddr",  32'(bus.flash_addr_out),   32'h000100);
    checkOutput("startEmpty", 32'(bus.instr_valid),      32'd0);
    bus.flash_busy = 1'b1;
    step();
    checkOutput("startOnce", 32'(bus.flash_start_read), 32'd0);
    bus.flash_data_in    = 16'h1234;
    bus.flash_data_ready = 1'b1;
    step();
    expectHead("first", 16'h3412, 24'h000100);
    bus.flash_data_ready = 1'b0;
    step();
    applyStimulus(16'h5678, 1);
    expectHead("firstHeld", 16'h3412, 24'h000100);
    popOne();
    expectHead("second", 16'h7856, 24'h000102);
    popOne();
    checkOutput("drainedValid", 32'(bus.instr_valid), 32'd0);

    $display("[TB] fill to stall, hold last word, drain");
    applyStimulus(16'hA1B2, 1);
    applyStimulus(16'hC3D4, 1);
    checkOutput("stallAt2", 32'(bus.flash_stall_read), 32'd0);
    applyStimulus(16'hE5F6, 1);
    checkOutput("stallAt3", 32'(bus.flash_stall_read), 32'd1);
    applyStimulus(16'h0718, 5);
    checkOutput("stallAt4", 32'(bus.flash_stall_read), 32'd1);
    expectHead("fill0", 16'hB2A1, 24'h000104);
    popOne();
    expectHead("fill1", 16'hD4C3, 24'h000106);
    checkOutput("stallDrain3", 32'(bus.flash_stall_read), 32'd1);
    popOne();
    expectHead("fill2", 16'hF6E5, 24'h000108);
    checkOutput("stallDrain2", 32'(bus.flash_stall_read), 32'd0);
    popOne();
    expectHead("fill3", 16'h1807, 24'h00010A);
    popOne();
    checkOutput("fillEmpty", 32'(bus.instr_valid), 32'd0);
    applyStimulus(16'h9ABC, 1);
    expectHead("resume", 16'hBC9A, 24'h00010C);
    popOne();

    $display("[TB] redirect to 0x000200 mid-stream");
    applyStimulus(16'h2233, 1);
    expectHead("preRedirect", 16'h3322, 24'h00010E);
    bus.fetch_addr_in    = 24'h000200;
    bus.fetch_start      = 1'b1;
    bus.flash_data_in    = 16'hDEAD;
    bus.flash_data_ready = 1'b1;
    step();
    bus.fetch_start      = 1'b0;
    bus.flash_data_ready = 1'b0;
    checkOutput("redirStop",  32'(bus.flash_stop_read),  32'd1);
    checkOutput("redirFlush", 32'(bus.instr_valid),      32'd0);
    checkOutput("redirNoStart", 32'(bus.flash_start_read), 32'd0);
    step();
    checkOutput("redirStopOnce", 32'(bus.flash_stop_read), 32'd0);
    checkOutput("redirBusyWait", 32'(bus.flash_start_read), 32'd0);
    bus.flash_busy = 1'b0;
    waitStartPulse("redir", 24'h000200);
    bus.flash_busy = 1'b1;
    step();
    checkOutput("redirStartOnce", 32'(bus.flash_start_read), 32'd0);
    checkOutput("redirStillEmpty", 32'(bus.instr_valid), 32'd0);
    applyStimulus(16'h4455, 1);
    expectHead("postRedirect", 16'h5544, 24'h000200);

    $display("[TB] push and pop together at count 3");
    applyStimulus(16'h6677, 1);
    applyStimulus(16'h8899, 1);
    checkOutput("count3", 32'(dut.count_q), 32'd3);
    bus.flash_data_in    = 16'hAABB;
    bus.flash_data_ready = 1'b1;
    bus.instr_ready      = 1'b1;
    step();
    bus.flash_data_ready = 1'b0;
    bus.instr_ready      = 1'b0;
    checkOutput("countSame", 32'(dut.count_q), 32'd3);
    expectHead("pp0", 16'h7766, 24'h000202);
    step();
    popOne();
    expectHead("pp1", 16'h9988, 24'h000204);
    popOne();
    expectHead("pp2", 16'hBBAA, 24'h000206);
    popOne();
    checkOutput("ppEmpty", 32'(bus.instr_valid), 32'd0);

    $display("[TB] address wrap from 0xFFFFFE");
    bus.fetch_addr_in = 24'hFFFFFF;
    bus.fetch_start   = 1'b1;
    step();
    bus.fetch_start = 1'b0;
    checkOutput("wrapStop", 32'(bus.flash_stop_read), 32'd1);
    bus.flash_busy = 1'b0;
    step();
    waitStartPulse("wrap", 24'hFFFFFE);
    bus.flash_busy = 1'b1;
    step();
    applyStimulus(16'h0102, 1);
    applyStimulus(16'h0304, 1);
    expectHead("wrapHi", 16'h0201, 24'hFFFFFE);
    popOne();
    expectHead("wrapLo", 16'h0403, 24'h000000);

    $display("[TB] fetch_stop mid-stream, then stop/start collisions");
    bus.fetch_stop = 1'b1;
    step();
    bus.fetch_stop = 1'b0;
    bus.flash_busy = 1'b0;
    checkOutput("stopPulse", 32'(bus.flash_stop_read), 32'd1);
    checkOutput("stopFlush", 32'(bus.instr_valid),     32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput("idleNoStart", 32'(bus.flash_start_read), 32'd0);
      checkOutput("idleNoStop",  32'(bus.flash_stop_read),  32'd0);
    end
    bus.fetch_stop = 1'b1;
    step();
    bus.fetch_stop = 1'b0;
    checkOutput("idleStopIgnored", 32'(bus.flash_stop_read), 32'd0);
    bus.fetch_addr_in = 24'h000300;
    bus.fetch_start   = 1'b1;
    bus.fetch_stop    = 1'b1;
    step();
    bus.fetch_start = 1'b0;
    bus.fetch_stop  = 1'b0;
    checkOutput("bothStart", 32'(bus.flash_start_read), 32'd1);
    checkOutput("bothAddr",  32'(bus.flash_addr_out),   32'h000300);
    checkOutput("bothNoStop", 32'(bus.flash_stop_read), 32'd0);
    bus.flash_busy = 1'b1;
    step();
    applyStimulus(16'hCAFE, 1);
    expectHead("beforeReset", 16'hFECA, 24'h000300);

    $display("[TB] asynchronous reset mid-stream");
    #2;
    rstn = 1'b0;
    #1;
    expectAllZero("asyncReset");
    step();
    rstn           = 1'b1;
    bus.flash_busy = 1'b0;
    step();
    applyStimulus(16'h1357, 1);
    applyStimulus(16'h2468, 2);
    checkOutput("postResetValid", 32'(bus.instr_valid),      32'd0);
    checkOutput("postResetStart", 32'(bus.flash_start_read), 32'd0);
    checkOutput("postResetStall", 32'(bus.flash_stall_read), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
